// File: rtl/bin2bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_pkg
//
// Shared definitions for the sequential binary-to-BCD converter:
//   BCD_DIGIT_W : width of one BCD digit (nibble)
//   state_t     : converter FSM states (IDLE, SHIFT, DONE)
//   max_dec()   : largest decimal value representable in a given number of
//                 BCD digits (10^digits - 1), used for overflow detection
// ---------------------------------------------------------------------------
package bin2bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // 10^digits - 1, evaluated at elaboration time for localparams.
  function automatic int max_dec(input int digits);
    int acc;
    acc = 1;
    for (int i = 0; i < digits; i++) begin
      acc = acc * 10;
    end
    return acc - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
//
// Combinational correction cell of the double-dabble algorithm. A BCD digit
// of 5 or more would become 10 or more after the next left shift, so it is
// pre-corrected by +3 so the shift carries cleanly into the next digit.
//
// Ports:
//   in_i  [3:0]  BCD digit before correction
//   out_o [3:0]  corrected digit: (in_i >= 5) ? in_i + 3 : in_i
// ---------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  // Only values 0..9 occur in a legal BCD field; the 4-bit sum cannot
  // carry out for those, so the result is kept at 4 bits.
  always_comb begin
    out_o = in_i;
    if (in_i >= 4'd5) begin
      out_o = in_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A conversion is accepted when start is high outside SHIFT; the result
// appears WIDTH+1 cycles later together with a one-cycle done pulse.
// Results (bcd_out, ovf, neg) hold until the next conversion completes.
//
// Optional feature macro: BIN2BCD_SIGNED_EN
//   defined   : bin_in is two's complement; its magnitude is converted and
//               neg reports the sign.
//   undefined : bin_in is unsigned and neg is tied low.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    conversion request, sampled when not busy
//   bin_in   [WIDTH-1:0] binary operand, captured on the accepting edge
//   busy     conversion in progress
//   done     one-cycle pulse, results valid from this cycle on
//   bcd_out  [4*DIGITS-1:0] BCD digits, most significant digit on top
//   ovf      input exceeded 10^DIGITS-1 (bcd_out then reads all nines)
//   neg      input was negative (signed mode only)
// ---------------------------------------------------------------------------
import bin2bcd_pkg::*;

module bin2bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          ovf,
  output logic                          neg
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH:0]   MAX_VAL   = (WIDTH + 1)'(max_dec(DIGITS));
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   shift_q, shift_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              ovf_q, ovf_d;

  logic [WIDTH-1:0]  mag_in;
  logic              load_ovf;
  logic [BCD_W-1:0]  adj_bcd;
  logic [SR_W-1:0]   adjusted;
  logic [SR_W-1:0]   shifted;

`ifdef BIN2BCD_SIGNED_EN
  logic              neg_pend_q, neg_pend_d;
  logic              neg_q, neg_d;

  // Two's-complement magnitude kept at WIDTH bits, so the most negative
  // value maps onto its own bit pattern read as unsigned (-8192 -> 8192).
  assign mag_in = bin_in[WIDTH-1]
                ? ((~bin_in) + {{(WIDTH-1){1'b0}}, 1'b1})
                : bin_in;
`else
  assign mag_in = bin_in;
`endif

  assign load_ovf = ({1'b0, mag_in} > MAX_VAL);

  // One add-3 correction cell per BCD digit of the shift register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .in_i  (shift_q[WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .out_o (adj_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Correct the digit field first, then shift the whole register left.
  assign adjusted = {adj_bcd, shift_q[WIDTH-1:0]};
  assign shifted  = {adjusted[SR_W-2:0], 1'b0};

  // Next-state and datapath update. Loading is shared between IDLE and
  // DONE so back-to-back conversions cost no idle cycle; in SHIFT the
  // start input is simply not looked at.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
    neg_pend_d = neg_pend_q;
    neg_d      = neg_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d    = SHIFT;
          cnt_d      = '0;
          shift_d    = {{BCD_W{1'b0}}, mag_in};
          ovf_pend_d = load_ovf;
`ifdef BIN2BCD_SIGNED_EN
          neg_pend_d = bin_in[WIDTH-1];
`endif
        end
      end

      SHIFT: begin
        shift_d = shifted;
        cnt_d   = cnt_q + CNT_W'(1);
        // The last iteration publishes the freshly shifted digit field.
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          bcd_d   = ovf_pend_q ? ALL_NINES : shifted[SR_W-1 -: BCD_W];
          ovf_d   = ovf_pend_q;
`ifdef BIN2BCD_SIGNED_EN
          neg_d   = neg_pend_q;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any conversion in flight
  // and clears the published result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
`ifdef BIN2BCD_SIGNED_EN
      neg_pend_q <= neg_pend_d;
      neg_q      <= neg_d;
`endif
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

`ifdef BIN2BCD_SIGNED_EN
  assign neg = neg_q;
`else
  assign neg = 1'b0;
`endif

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter for the calculator datapath. It is the inverse of the digit-weighting path, which builds a binary value from BCD digits as d3·1000 + d2·100 + d1·10 + d0. This block takes the 14-bit binary result and returns four BCD digits for the display/digit-select logic. It uses shift-and-add-3 (double dabble), one bit per clock, with a start/busy/done handshake.

Parameters:
WIDTH, 14, binary input width
DIGITS, 4, number of BCD output digits (4 bits each)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request conversion; sampled when not busy
bin_in  input  WIDTH  binary operand; captured on the accepting edge only
busy  output  1  conversion in progress
done  output  1  one-cycle pulse: results valid from this cycle on
bcd_out  output  4*DIGITS  digits; [15:12] thousands … [3:0] units
ovf  output  1  input exceeds 10^DIGITS−1
neg  output  1  input was negative (signed mode only, else 0)

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-conversion):
  - state←IDLE; busy, done, ovf, neg ← 0; bcd_out ← 0; iteration counter ← 0.
  - Any conversion in flight is discarded.
- States:
  - IDLE: busy=0. start=1 → load, go to SHIFT.
  - SHIFT: busy=1. Performs WIDTH iterations, then goes to DONE.
  - DONE: done=1, busy=0 for exactly one cycle. start=1 here is accepted like IDLE (back-to-back conversions); otherwise go to IDLE.
- Load (edge N):
  - Shift register ← {DIGITS*4 zeros, bin_in}.
  - cnt←0.
  - ovf_pending ← (bin_in > 10^DIGITS−1), compared at WIDTH+1 bits unsigned.
- Iteration (edges N+1 … N+WIDTH):
  - Each BCD nibble ≥5 gets +3 (4-bit, no carry out).
  - Then the whole register shifts left by 1.
  - cnt increments.
- At edge N+WIDTH (cnt==WIDTH−1):
  - bcd_out ← BCD field; ovf ← ovf_pending; state←DONE.
  - done is high in the cycle after edge N+WIDTH.
  - Latency: start edge to done = WIDTH+1 cycles (15 at default).
- Overflow: ovf=1 forces bcd_out to all-9s (9999 at default). It is never a partial/garbage value.
- Output holding: bcd_out, ovf and neg hold their values until the next accepted start completes. They are not cleared on start.
- start while in SHIFT: ignored, with no side effects; bin_in is not re-sampled.
- bin_in may change freely after the accepting edge.

Optional Feature:
Macro BIN2BCD_SIGNED_EN.
- Defined:
  - bin_in is two's complement. At load, magnitude = MSB ? −bin_in : bin_in, and neg_pending = MSB.
  - Magnitude is computed at WIDTH bits unsigned, so −8192 gives 8192.
  - neg ← neg_pending at the same edge as bcd_out.
  - ovf is computed on the magnitude. At default WIDTH it can never assert.
- Undefined: input is unsigned and neg is tied 0.
- Latency is identical in both modes.

Decomposition:
- Package bin2bcd_pkg holds:
  - BCD_DIGIT_W=4
  - state typedef enum {IDLE, SHIFT, DONE}
  - function max_dec(DIGITS) returning 10^DIGITS−1
- Counter width is $clog2(WIDTH).
- One sub-module, bcd_add3: combinational 4-bit cell, out = (in≥5) ? in+3 : in. It is instantiated DIGITS times with generate.

Test Plan:
1. rst 2 cycles, then start with bin_in=1234 → busy high 14 cycles; done pulse on cycle 15; bcd_out=16'h1234, ovf=0, neg=0.
2. Boundary values:
   - bin_in=0 → bcd_out=16'h0000.
   - bin_in=9999 → 16'h9999, ovf=0.
   - bin_in=10000 → 16'h9999, ovf=1.
   - bin_in=16383 → 16'h9999, ovf=1.
3. start=1 continuously with bin_in=42, then 7 on the DONE cycle → two conversions back-to-back, 15 cycles apart; results 16'h0042 then 16'h0007. start during SHIFT changes nothing.
4. Start 5678 and assert rst at cycle 6 → next cycle busy=0, done=0, bcd_out=0. A following start with 5678 gives 16'h5678 with no stale bits.
5. Compare against a reference model: 500 random bin_in in 0…16383 → bcd_out equals the decimal digits (or 9999+ovf). done never pulses without a preceding accepted start.
6. BIN2BCD_SIGNED_EN defined:
   - 14'h3FFF → neg=1, 16'h0001.
   - 14'h2000 → neg=1, 16'h8192, ovf=0.
   - 14'h1FFF → neg=0, 16'h8191.
